hcsr04_echo_timer: RTL and testbench

HCSR04_ECHO_TIMER -- requirements
Module: hcsr04_echo_timer

---
 rtl/hcsr04_pkg.sv | 27 ++
 rtl/hcsr04_echo_timer_sync.sv | 30 +++
 rtl/hcsr04_echo_timer.sv | 256 +++++++++++++++++++++++++
 tb/tb_hcsr04_echo_timer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// ----------------------------------------------------------------------------
// hcsr04_pkg
// Shared definitions for the HC-SR04 echo timer:
//   - state_t      : measurement FSM state encoding (exported on o_state)
//   - DEF_*        : default parameter values for hcsr04_echo_timer
// ----------------------------------------------------------------------------
package hcsr04_pkg;

    // Encoding is visible to software through the status register, so the
    // numeric values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_RISE = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // 10 us trigger at 64 MHz
    localparam int DEF_TRIG_CYCLES    = 640;
    // 25 ms: no-echo / over-range limit
    localparam int DEF_TIMEOUT_CYCLES = 1_600_000;
    // 64 ms between trigger starts
    localparam int DEF_PERIOD_CYCLES  = 4_096_000;
    localparam int DEF_CNT_W          = 24;

endpackage

// File: rtl/hcsr04_echo_timer_sync.sv
// ----------------------------------------------------------------------------
// hcsr04_sync
// Two-flop synchroniser that brings the asynchronous echo pin into the i_clk
// domain.
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, clears both flops
//   i_async : asynchronous input
//   o_sync  : synchronised output (second flop)
// ----------------------------------------------------------------------------
module hcsr04_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta   <= 1'b0;
            o_sync <= 1'b0;
        end else begin
            meta   <= i_async;
            o_sync <= meta;
        end
    end

endmodule

// File: rtl/hcsr04_echo_timer.sv
// ----------------------------------------------------------------------------
// hcsr04_echo_timer
// Drives the HC-SR04 trigger pin, then times the width of the echo pulse in
// i_clk cycles. Measurements repeat no faster than once per PERIOD_CYCLES.
//
// Optional build macro HCSR04_AVG_EN: when defined, o_echo_cycles reports the
// mean of the last 4 non-timeout results instead of the raw result.
//
// Parameters:
//   TRIG_CYCLES    : trigger high time in cycles
//   TIMEOUT_CYCLES : max wait for echo rise and max echo width
//   PERIOD_CYCLES  : minimum spacing between trigger starts
//   CNT_W          : counter and result width
// Ports:
//   i_clk         : clock, all logic on rising edge
//   i_rst         : synchronous active-high reset
//   i_enable      : permits a new measurement to start (sampled in IDLE only)
//   i_echo        : asynchronous echo pin
//   o_trigger     : registered trigger pin
//   o_echo_cycles : last result, held until the next o_valid
//   o_valid       : one-cycle pulse when o_echo_cycles/o_timeout update
//   o_timeout     : last result timed out
//   o_busy        : FSM not in IDLE
//   o_state       : FSM state encoding
// ----------------------------------------------------------------------------
module hcsr04_echo_timer
    import hcsr04_pkg::*;
#(
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_echo,
    output logic             o_trigger,
    output logic [CNT_W-1:0] o_echo_cycles,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_busy,
    output logic [2:0]       o_state
);

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_t           state;
    state_t           next_state;
    logic             echo_s;
    logic             echo_d;
    logic             echo_rise;
    logic             echo_fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] period_next;
    logic             trigger_next;
    logic             done;
    logic             done_timeout;
    logic [CNT_W-1:0] done_value;
    logic             result_load;
    logic [CNT_W-1:0] result_data;

    hcsr04_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_echo),
        .o_sync  (echo_s)
    );

    // Edges are taken against the previous synchronised sample, so a level
    // that is already high when WAIT_RISE is entered is never seen as a rise.
    assign echo_rise = echo_s & ~echo_d;
    assign echo_fall = ~echo_s & echo_d;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_enable) next_state = ST_TRIG;
            end
            ST_TRIG: begin
                if (cnt == TRIG_LAST) next_state = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (echo_rise)                next_state = ST_MEASURE;
                else if (cnt == TIMEOUT_LAST) next_state = ST_HOLDOFF;
            end
            ST_MEASURE: begin
                if (echo_fall)               next_state = ST_HOLDOFF;
                else if (cnt >= TIMEOUT_VAL) next_state = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                // >= rather than == so a measurement that overruns the
                // period still releases the FSM straight away.
                if (period_cnt >= PERIOD_LAST) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output / counter-update logic
    always_comb begin
        cnt_next     = cnt;
        period_next  = period_cnt;
        trigger_next = (next_state == ST_TRIG);
        done         = 1'b0;
        done_timeout = 1'b0;
        done_value   = '0;

        // Period counter is held at zero in IDLE so it counts from TRIG
        // entry; it saturates instead of wrapping.
        if (state == ST_IDLE) begin
            period_next = '0;
        end else if (period_cnt < PERIOD_LAST) begin
            period_next = period_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                cnt_next = '0;
            end
            ST_TRIG: begin
                if (cnt == TRIG_LAST) cnt_next = '0;
                else                  cnt_next = cnt + 1'b1;
            end
            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    // The cycle that shows the rise is the first high cycle.
                    cnt_next = CNT_W'(1);
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_next     = '0;
                    done         = 1'b1;
                    done_timeout = 1'b1;
                    done_value   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    done         = 1'b1;
                    done_timeout = 1'b0;
                    done_value   = cnt;
                end else if (cnt >= TIMEOUT_VAL) begin
                    done         = 1'b1;
                    done_timeout = 1'b1;
                    done_value   = TIMEOUT_VAL;
                end else if (echo_s) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                cnt_next = cnt;
            end
        endcase
    end

`ifdef HCSR04_AVG_EN
    // Sliding window of the last 4 good results. Timeouts never enter the
    // window, and until it fills the mean is taken over the entries present.
    localparam logic [CNT_W+1:0] THREE = (CNT_W+2)'(3);

    logic [CNT_W-1:0] win0;
    logic [CNT_W-1:0] win1;
    logic [CNT_W-1:0] win2;
    logic [CNT_W-1:0] win3;
    logic [2:0]       avg_count;
    logic [2:0]       count_next;
    logic [CNT_W+1:0] avg_sum;
    logic [CNT_W+1:0] sum_next;
    logic [CNT_W-1:0] mean_next;

    always_comb begin
        sum_next = avg_sum + (CNT_W+2)'(done_value);
        if (avg_count == 3'd4) begin
            sum_next = sum_next - (CNT_W+2)'(win3);
        end
        count_next = (avg_count == 3'd4) ? 3'd4 : avg_count + 3'd1;
        case (count_next)
            3'd1:    mean_next = CNT_W'(sum_next);
            3'd2:    mean_next = CNT_W'(sum_next >> 1);
            3'd3:    mean_next = CNT_W'(sum_next / THREE);
            default: mean_next = CNT_W'(sum_next >> 2);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            win0      <= '0;
            win1      <= '0;
            win2      <= '0;
            win3      <= '0;
            avg_count <= '0;
            avg_sum   <= '0;
        end else if (done && !done_timeout) begin
            win0      <= done_value;
            win1      <= win0;
            win2      <= win1;
            win3      <= win2;
            avg_count <= count_next;
            avg_sum   <= sum_next;
        end
    end

    // A timeout updates o_timeout but leaves the reported average alone.
    assign result_load = done & ~done_timeout;
    assign result_data = mean_next;
`else
    assign result_load = done;
    assign result_data = done_value;
`endif

    // Counters, echo history and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt           <= '0;
            period_cnt    <= '0;
            echo_d        <= 1'b0;
            o_trigger     <= 1'b0;
            o_valid       <= 1'b0;
            o_timeout     <= 1'b0;
            o_echo_cycles <= '0;
        end else begin
            cnt        <= cnt_next;
            period_cnt <= period_next;
            echo_d     <= echo_s;
            o_trigger  <= trigger_next;
            o_valid    <= done;
            if (done) begin
                o_timeout <= done_timeout;
            end
            if (result_load) begin
                o_echo_cycles <= result_data;
            end
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_hcsr04_echo_timer.sv
// ----------------------------------------------------------------------------
// tb_hcsr04_echo_timer
// Directed bench for hcsr04_echo_timer with TRIG_CYCLES=4, TIMEOUT_CYCLES=100,
// PERIOD_CYCLES=200. Expected values follow HCSR04_AVG_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_hcsr04_echo_timer;

    localparam int CNT_W = 24;

    logic             i_clk;
    logic             i_rst;
    logic             i_enable;
    logic             i_echo;
    logic             o_trigger;
    logic [CNT_W-1:0] o_echo_cycles;
    logic             o_valid;
    logic             o_timeout;
    logic             o_busy;
    logic [2:0]       o_state;

    int checks = 0;
    int errors = 0;

    hcsr04_echo_timer #(
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (100),
        .PERIOD_CYCLES  (200),
        .CNT_W          (CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_echo        (i_echo),
        .o_trigger     (o_trigger),
        .o_echo_cycles (o_echo_cycles),
        .o_valid       (o_valid),
        .o_timeout     (o_timeout),
        .o_busy        (o_busy),
        .o_state       (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pulse_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // One enable pulse, echo pulse of 'width' cycles starting 10 cycles after
    // the trigger falls (width 0 = no echo), then wait for the result and IDLE.
    task automatic run_measure(input int width, output logic [CNT_W-1:0] val,
                               output logic to, output int nvalid, output bit ok);
        int n;
        ok     = 1'b1;
        nvalid = 0;
        val    = '0;
        to     = 1'b0;
        @(negedge i_clk);
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
        n = 0;
        while (o_trigger === 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) ok = 1'b0;
        repeat (10) @(negedge i_clk);
        if (width > 0) begin
            i_echo = 1'b1;
            repeat (width) @(negedge i_clk);
            i_echo = 1'b0;
        end
        n = 0;
        while (n < 150 && nvalid == 0) begin
            @(negedge i_clk);
            n++;
            if (o_valid === 1'b1) begin
                nvalid++;
                val = o_echo_cycles;
                to  = o_timeout;
            end
        end
        n = 0;
        while (o_busy !== 1'b0 && n < 400) begin
            @(negedge i_clk);
            n++;
            if (o_valid === 1'b1) nvalid++;
        end
        if (n >= 400) ok = 1'b0;
    endtask

    task automatic test_reset();
        i_rst    = 1'b1;
        i_enable = 1'b0;
        i_echo   = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_trigger !== 1'b0 || o_valid !== 1'b0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: trig=%b valid=%b to=%b busy=%b, required all 0",
                     o_trigger, o_valid, o_timeout, o_busy);
        end
        checks++;
        if (o_echo_cycles !== '0 || o_state !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: cycles=%0d state=%0d, required 0 0", o_echo_cycles, o_state);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_normal();
        int hi;
        logic [CNT_W-1:0] exp_val;
        exp_val = 37;
        @(negedge i_clk);
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
        hi = 0;
        while (o_trigger === 1'b1 && hi < 50) begin
            hi++;
            @(negedge i_clk);
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("[TB] FAIL trigger_width: %0d cycles, required 4", hi);
        end
        checks++;
        if (o_state !== 3'd2) begin
            errors++;
            $display("[TB] FAIL wait_rise_state: state=%0d, required 2", o_state);
        end
        repeat (10) @(negedge i_clk);
        i_echo = 1'b1;
        repeat (37) @(negedge i_clk);
        i_echo = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_early: o_valid=%b on 2nd edge, required 0", o_valid);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL valid_latency: o_valid=%b on 3rd edge, required 1", o_valid);
        end
        checks++;
        if (o_echo_cycles !== exp_val || o_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_result: cycles=%0d to=%b, required 37 0", o_echo_cycles, o_timeout);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_state !== 3'd4) begin
            errors++;
            $display("[TB] FAIL valid_width: valid=%b state=%0d, required 0 4", o_valid, o_state);
        end
        hi = 0;
        while (o_busy !== 1'b0 && hi < 400) begin
            @(negedge i_clk);
            hi++;
        end
        checks++;
        if (hi >= 400) begin
            errors++;
            $display("[TB] FAIL normal_idle: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_no_echo();
        int n;
        logic [CNT_W-1:0] exp_val;
`ifdef HCSR04_AVG_EN
        exp_val = 37;
`else
        exp_val = 0;
`endif
        @(negedge i_clk);
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
        n = 0;
        while (o_trigger === 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        n = 0;
        while (o_valid !== 1'b1 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (n != 100) begin
            errors++;
            $display("[TB] FAIL no_echo_latency: valid after %0d cycles, required 100", n);
        end
        checks++;
        if (o_echo_cycles !== exp_val || o_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_echo_result: cycles=%0d to=%b, required %0d 1",
                     o_echo_cycles, o_timeout, exp_val);
        end
        n = 0;
        while (o_busy !== 1'b0 && n < 400) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    task automatic test_long_echo();
        int n;
        int nval;
        bit saw_idle;
        logic [CNT_W-1:0] val;
        logic [CNT_W-1:0] exp_val;
        logic to;
        logic [2:0] st;
`ifdef HCSR04_AVG_EN
        exp_val = 37;
`else
        exp_val = 100;
`endif
        nval = 0;
        saw_idle = 1'b0;
        val = '0;
        to = 1'b0;
        st = 3'd0;
        @(negedge i_clk);
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
        n = 0;
        while (o_trigger === 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        for (int i = 0; i < 260; i++) begin
            i_echo = (i >= 5 && i < 155);
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                nval++;
                val = o_echo_cycles;
                to  = o_timeout;
                st  = o_state;
            end
            if (nval > 0 && o_state === 3'd0) saw_idle = 1'b1;
        end
        i_echo = 1'b0;
        checks++;
        if (nval != 1) begin
            errors++;
            $display("[TB] FAIL long_valid_count: %0d pulses, required 1", nval);
        end
        checks++;
        if (val !== exp_val || to !== 1'b1) begin
            errors++;
            $display("[TB] FAIL long_result: cycles=%0d to=%b, required %0d 1", val, to, exp_val);
        end
        checks++;
        if (st !== 3'd4 || !saw_idle) begin
            errors++;
            $display("[TB] FAIL long_states: state at valid=%0d idle_seen=%0d, required 4 1", st, saw_idle);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last_rise;
        int nrise;
        int nval;
        int badval;
        int rel;
        int n;
        int rises[3];
        logic prev_trig;
        pulse_reset();
        cyc = 0;
        last_rise = -1000;
        nrise = 0;
        nval = 0;
        badval = 0;
        prev_trig = 1'b0;
        rises = '{0, 0, 0};
        i_enable = 1'b1;
        while (cyc < 800 && !(nrise >= 3 && (cyc - last_rise) >= 60)) begin
            @(negedge i_clk);
            cyc++;
            if (o_trigger === 1'b1 && prev_trig === 1'b0) begin
                if (nrise < 3) rises[nrise] = cyc;
                nrise++;
                last_rise = cyc;
            end
            prev_trig = o_trigger;
            if (o_valid === 1'b1) begin
                nval++;
                if (o_echo_cycles !== CNT_W'(20) || o_timeout !== 1'b0) badval++;
            end
            rel = cyc - last_rise;
            i_echo = (rel >= 8 && rel < 28) || (rel >= 100 && rel < 120);
        end
        i_enable = 1'b0;
        i_echo = 1'b0;
        n = 0;
        while (o_busy !== 1'b0 && n < 400) begin
            @(negedge i_clk);
            n++;
            if (o_valid === 1'b1) nval++;
        end
        checks++;
        if (nrise < 3 || rises[1] - rises[0] != 201 || rises[2] - rises[1] != 201) begin
            errors++;
            $display("[TB] FAIL trigger_spacing: rises=%0d gaps %0d %0d, required 201 201",
                     nrise, rises[1] - rises[0], rises[2] - rises[1]);
        end
        checks++;
        if (nval != 3) begin
            errors++;
            $display("[TB] FAIL holdoff_valids: %0d pulses, required 3", nval);
        end
        checks++;
        if (badval != 0) begin
            errors++;
            $display("[TB] FAIL back_to_back_values: %0d bad results, required 0", badval);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int nval;
        logic [CNT_W-1:0] val;
        logic to;
        bit ok;
        @(negedge i_clk);
        i_enable = 1'b1;
        @(negedge i_clk);
        i_enable = 1'b0;
        n = 0;
        while (o_trigger === 1'b1 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        repeat (5) @(negedge i_clk);
        i_echo = 1'b1;
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_state !== 3'd3) begin
            errors++;
            $display("[TB] FAIL mid_measure_state: state=%0d, required 3", o_state);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_trigger !== 1'b0 || o_valid !== 1'b0 || o_timeout !== 1'b0 ||
            o_echo_cycles !== '0 || o_state !== 3'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: trig=%b valid=%b to=%b cycles=%0d state=%0d busy=%b, required all 0",
                     o_trigger, o_valid, o_timeout, o_echo_cycles, o_state, o_busy);
        end
        i_rst = 1'b0;
        nval = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) nval++;
        end
        i_echo = 1'b0;
        repeat (5) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) nval++;
        end
        checks++;
        if (nval != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_valid: %0d pulses busy=%b, required 0 0", nval, o_busy);
        end
        run_measure(25, val, to, nval, ok);
        checks++;
        if (!ok || nval != 1 || val !== CNT_W'(25) || to !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_measure: ok=%0d valids=%0d cycles=%0d to=%b, required 1 1 25 0",
                     ok, nval, val, to);
        end
    endtask

    task automatic test_average();
        int widths[5];
        int exp_vals[5];
        int nval;
        logic [CNT_W-1:0] val;
        logic to;
        bit ok;
        widths = '{40, 44, 48, 52, 0};
`ifdef HCSR04_AVG_EN
        exp_vals = '{40, 42, 44, 46, 46};
`else
        exp_vals = '{40, 44, 48, 52, 0};
`endif
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            run_measure(widths[i], val, to, nval, ok);
            checks++;
            if (!ok || nval != 1 || val !== CNT_W'(exp_vals[i]) || to !== (widths[i] == 0)) begin
                errors++;
                $display("[TB] FAIL average_step%0d: ok=%0d valids=%0d cycles=%0d to=%b, required 1 1 %0d %0d",
                         i, ok, nval, val, to, exp_vals[i], (widths[i] == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_no_echo();
        test_long_echo();
        test_back_to_back();
        test_reset_mid();
        test_average();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
